// File: rtl/lum_pkg.sv
// Shared definitions for the backlight PWM: FSM states, level count and the
// level-to-duty table (table values are for a 12-bit PWM counter).
package lum_pkg;

  localparam int LUM_LEVELS = 32;
  localparam int LVL_W      = 5;
  localparam int LUT_BITS   = 12;
  localparam int LUT_W      = LUT_BITS + 1;

  typedef enum logic [1:0] {IDLE, HOLD, RAMP_UP, RAMP_DOWN} lum_state_e;

  typedef logic [LUM_LEVELS-1:0][LUT_W-1:0] duty_lut_t;

  // Linear 132/level, with the top level pinned to a full period (always on).
  function automatic duty_lut_t build_duty_lut();
    duty_lut_t lut;
    for (int l = 0; l < LUM_LEVELS; l++)
      lut[l] = (l == LUM_LEVELS-1) ? LUT_W'(1 << LUT_BITS) : LUT_W'(l * 132);
    return lut;
  endfunction

  localparam duty_lut_t DUTY_LUT = build_duty_lut();

  // Rescale the 12-bit table to another counter width (duty * 2^bits / 4096).
  function automatic logic [31:0] scale_duty(input logic [LVL_W-1:0] lvl, input int bits);
    logic [31:0] v;
    v = 32'(DUTY_LUT[lvl]);
    if (bits >= LUT_BITS) return v << (bits - LUT_BITS);
    return v >> (LUT_BITS - bits);
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Period counter, boundary-latched duty register and registered comparator.
module pwm_gen
  import lum_pkg::*;
#(
  parameter int PWM_BITS = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [PWM_BITS:0] duty_nxt,
  output logic              boundary,
  output logic              pwm_out
);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS:0]   duty_q;

  assign boundary = run && (cnt == '1);

  // Duty only changes on the last count so a period is never cut short.
  always_ff @(posedge clock) begin
    if (reset || !run) begin
      cnt     <= '0;
      duty_q  <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + PWM_BITS'(1);
      if (boundary) duty_q <= duty_nxt;
      pwm_out <= ({1'b0, cnt} < duty_q);
    end
  end

endmodule

// File: rtl/lum_pwm.sv
// Backlight PWM with slew-limited brightness: steps one level every
// RAMP_PERIODS PWM periods toward the requested level.
module lum_pwm
  import lum_pkg::*;
#(
  parameter int PWM_BITS     = 12,
  parameter int RAMP_PERIODS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [LVL_W-1:0] lum_level,
  output logic             pwm_out,
  output logic [LVL_W-1:0] cur_level,
  output logic             ramping
);

  localparam int          DW       = PWM_BITS + 1;
  localparam logic [7:0]  DIV_LAST = 8'(RAMP_PERIODS - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LUM_LEVELS - 1);

  lum_state_e       state, state_nxt;
  logic [LVL_W-1:0] target_q, level_nxt;
  logic [7:0]       divider, div_nxt;
  logic             run, boundary;
  logic [DW-1:0]    duty_nxt;

  assign run      = enable && (state != IDLE);
  assign duty_nxt = DW'(scale_duty(level_nxt, PWM_BITS));

  // Divider keeps counting across a target reversal; it only resets on a step
  // or while the level already matches the target.
  always_comb begin
    level_nxt = cur_level;
    div_nxt   = divider;
    if (cur_level == target_q) begin
      div_nxt = '0;
    end else if (boundary) begin
      if (divider == DIV_LAST) begin
        div_nxt = '0;
        if (target_q > cur_level && cur_level != LVL_MAX)
          level_nxt = cur_level + LVL_W'(1);
        else if (target_q < cur_level && cur_level != '0)
          level_nxt = cur_level - LVL_W'(1);
      end else begin
        div_nxt = divider + 8'd1;
      end
    end
  end

  always_comb begin
    if (level_nxt < target_q)      state_nxt = RAMP_UP;
    else if (level_nxt > target_q) state_nxt = RAMP_DOWN;
    else                           state_nxt = HOLD;
  end

  always_ff @(posedge clock) begin
    target_q <= reset ? '0 : lum_level;
    if (reset || !enable) begin
      state     <= IDLE;
      cur_level <= '0;
      divider   <= '0;
      ramping   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_level <= level_nxt;
      divider   <= div_nxt;
      ramping   <= (state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN);
    end
  end

  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm_gen (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .duty_nxt (duty_nxt),
    .boundary (boundary),
    .pwm_out  (pwm_out)
  );

endmodule

// File: tb/tb_lum_pwm.sv
// Bench for lum_pwm: three instances (12-bit/2-period, 6-bit/4-period,
// 4-bit/1-period) exercised one after another against spec-derived values.
module tb_lum_pwm;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rst_c, en_a, en_b, en_c;
  logic [4:0] lvl_a, lvl_b, lvl_c, cur_a, cur_b, cur_c;
  logic       pwm_a, pwm_b, pwm_c, ramp_a, ramp_b, ramp_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lum_pwm #(.PWM_BITS(12), .RAMP_PERIODS(2)) u_a (
    .clock(clk), .reset(rst_a), .enable(en_a), .lum_level(lvl_a),
    .pwm_out(pwm_a), .cur_level(cur_a), .ramping(ramp_a));
  lum_pwm #(.PWM_BITS(6), .RAMP_PERIODS(4)) u_b (
    .clock(clk), .reset(rst_b), .enable(en_b), .lum_level(lvl_b),
    .pwm_out(pwm_b), .cur_level(cur_b), .ramping(ramp_b));
  lum_pwm #(.PWM_BITS(4), .RAMP_PERIODS(1)) u_c (
    .clock(clk), .reset(rst_c), .enable(en_c), .lum_level(lvl_c),
    .pwm_out(pwm_c), .cur_level(cur_c), .ramping(ramp_c));

  typedef struct {
    logic [4:0] lvl;
    int wait_cyc;
    int exp_lvl;
    int exp_ramp;
    int exp_high;
  } vec_t;

  vec_t vecs[4];
  vec_t sb[$];
  int   lvl_sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected high cycles per period: table value rescaled to a 2^b counter.
  function automatic int dexp(input int l, input int b);
    if (l == 31) return 1 << b;
    return (l * 132 * (1 << b)) / 4096;
  endfunction

  function automatic logic pwm_of(input int d);
    case (d)
      0:       return pwm_a;
      1:       return pwm_b;
      default: return pwm_c;
    endcase
  endfunction

  task automatic high_cnt(input int d, input int n, output int h);
    h = 0;
    repeat (n) begin
      @(negedge clk);
      h += int'(pwm_of(d));
    end
  endtask

  task automatic chk_b(input string tag, input int lvl, input int rmp);
    chk({tag, "_cur"}, int'(cur_b), lvl);
    chk({tag, "_ramp"}, int'(ramp_b), rmp);
  endtask

  initial begin
    int h, exp_cur;
    vec_t e;
    rst_a = 1; rst_b = 1; rst_c = 1;
    en_a = 1; en_b = 1; en_c = 1;
    lvl_a = 5'd31; lvl_b = 5'd2; lvl_c = 5'd31;

    // Instance A: reset with enable high, then ramp to 2 and measure duty.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("a_rst%0d_pwm", i), int'(pwm_a), 0);
      chk($sformatf("a_rst%0d_cur", i), int'(cur_a), 0);
      chk($sformatf("a_rst%0d_ramp", i), int'(ramp_a), 0);
    end
    rst_a = 0;
    @(negedge clk);
    chk("a_post_rst_pwm", int'(pwm_a), 0);
    chk("a_post_rst_cur", int'(cur_a), 0);
    chk("a_post_rst_ramp", int'(ramp_a), 0);
    lvl_a = 5'd2;
    repeat (9216) @(negedge clk);
    chk("a_lvl1_cur", int'(cur_a), 1);
    chk("a_lvl1_ramp", int'(ramp_a), 1);
    high_cnt(0, 4096, h);
    chk("a_lvl1_high", h, dexp(1, 12));
    repeat (4096) @(negedge clk);
    chk("a_lvl2_cur", int'(cur_a), 2);
    chk("a_lvl2_ramp", int'(ramp_a), 0);
    high_cnt(0, 4096, h);
    chk("a_lvl2_high", h, dexp(2, 12));
    rst_a = 1;

    // Instance B: 64-cycle periods, 4 periods per step.
    vecs[0] = '{lvl: 5'd2,  wait_cyc: 32,   exp_lvl: 0,  exp_ramp: 1, exp_high: dexp(0, 6)};
    vecs[1] = '{lvl: 5'd2,  wait_cyc: 192,  exp_lvl: 1,  exp_ramp: 1, exp_high: dexp(1, 6)};
    vecs[2] = '{lvl: 5'd2,  wait_cyc: 192,  exp_lvl: 2,  exp_ramp: 0, exp_high: dexp(2, 6)};
    vecs[3] = '{lvl: 5'd31, wait_cyc: 7424, exp_lvl: 31, exp_ramp: 0, exp_high: dexp(31, 6)};
    @(negedge clk);
    rst_b = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      lvl_b = vecs[i].lvl;
      sb.push_back(vecs[i]);
      repeat (vecs[i].wait_cyc) @(negedge clk);
      e = sb.pop_front();
      chk_b($sformatf("b_vec%0d", i), e.exp_lvl, e.exp_ramp);
      high_cnt(1, 64, h);
      chk($sformatf("b_vec%0d_high", i), h, e.exp_high);
    end

    // Enable drop from full brightness, then again mid-ramp at level 7.
    en_b = 0; lvl_b = 5'd10;
    @(negedge clk);
    chk("b_off1_pwm", int'(pwm_b), 0);
    chk_b("b_off1", 0, 0);
    en_b = 1;
    repeat (1922) @(negedge clk);
    chk_b("b_lvl7", 7, 1);
    chk("b_lvl7_pwm", int'(pwm_b), 1);
    en_b = 0;
    @(negedge clk);
    chk("b_off2_pwm", int'(pwm_b), 0);
    chk_b("b_off2", 0, 0);
    en_b = 1;
    @(negedge clk);
    repeat (160) @(negedge clk);
    chk_b("b_reen0", 0, 1);
    repeat (128) @(negedge clk);
    chk_b("b_reen1", 1, 1);

    // Reversal at level 5 with the divider part-way through a step.
    repeat (1152) @(negedge clk);
    chk_b("b_at5", 5, 1);
    lvl_b = 5'd3;
    repeat (64) @(negedge clk);
    chk_b("b_rev5", 5, 1);
    repeat (64) @(negedge clk);
    chk_b("b_rev4", 4, 1);
    repeat (192) @(negedge clk);
    chk_b("b_rev4_late", 4, 1);
    repeat (64) @(negedge clk);
    chk_b("b_rev3", 3, 0);
    high_cnt(1, 64, h);
    chk("b_rev3_high", h, dexp(3, 6));
    rst_b = 1;

    // Instance C: one step per 16-cycle period, target toggling every 3 periods.
    @(negedge clk);
    rst_c = 0;
    @(negedge clk);
    exp_cur = 0;
    chk("c_start", int'(cur_c), exp_cur);
    lvl_sb.push_back(1); lvl_sb.push_back(2); lvl_sb.push_back(3);
    for (int t = 1; t <= 192; t++) begin
      @(negedge clk);
      if (t % 16 == 0) begin
        if (lvl_sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL c_sb_empty: got no expectation at t=%0d, required one", t);
        end else begin
          exp_cur = lvl_sb.pop_front();
        end
      end
      chk($sformatf("c_t%0d", t), int'(cur_c), exp_cur);
      if (t == 48 || t == 144) begin
        lvl_c = 5'd0;
        lvl_sb.push_back(2); lvl_sb.push_back(1); lvl_sb.push_back(0);
      end else if (t == 96) begin
        lvl_c = 5'd31;
        lvl_sb.push_back(1); lvl_sb.push_back(2); lvl_sb.push_back(3);
      end
    end
    rst_c = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lum_pwm.md
LUM_PWM -- requirements
Module: lum_pwm

Interface
REQ-001 SHALL have parameter PWM_BITS, default 12, PWM counter width (period = 2^PWM_BITS clock cycles).
REQ-002 SHALL have parameter RAMP_PERIODS, default 4, number of PWM periods per one-level ramp step (range 1..255).
REQ-003 SHALL have port clock  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  backlight enable; 0 forces dark.
REQ-006 SHALL have port lum_level  input  5  requested brightness level 0..31, from the luminance converter output.
REQ-007 SHALL have port pwm_out  output  1  registered backlight PWM drive.
REQ-008 SHALL have port cur_level  output  5  level currently applied to the PWM.
REQ-009 SHALL have port ramping  output  1  high while cur_level differs from the target and a ramp is in progress.

Function
REQ-010 SHALL register lum_level into target_q every cycle; all decisions use target_q (1-cycle input latency).
REQ-011 SHALL run period counter cnt 0..2^PWM_BITS-1 while in any non-IDLE state, wrapping to 0; a period boundary is the cycle where cnt is at its maximum.
REQ-012 SHALL count completed periods in a ramp divider; at a boundary with divider == RAMP_PERIODS-1, SHALL step cur_level by +1 or -1 toward target_q and clear the divider; otherwise increment the divider.
REQ-013 SHALL not step, and SHALL hold the divider at 0, when cur_level == target_q.
REQ-014 SHALL load duty_q = DUTY_LUT[new cur_level] only at a period boundary (glitch-free duty updates).
REQ-015 SHALL drive pwm_out, registered, = (state != IDLE) && (cnt < duty_q); a duty value of 2^PWM_BITS SHALL give constant high.
REQ-016 SHALL use DUTY_LUT[L] = L*132 for L in 0..30 and DUTY_LUT[31] = 4096 (values for PWM_BITS = 12).
REQ-017 SHALL implement FSM states IDLE, HOLD, RAMP_UP, RAMP_DOWN.
REQ-018 IDLE -> RAMP_UP when enable = 1 and target_q > 0; IDLE -> HOLD when enable = 1 and target_q = 0.
REQ-019 HOLD/RAMP_* SHALL select RAMP_UP if target_q > cur_level, RAMP_DOWN if less, HOLD if equal, re-evaluated every cycle; a target reversal mid-ramp SHALL NOT clear the divider.
REQ-020 Any state -> IDLE on the cycle after enable = 0; in IDLE, cnt, divider, cur_level and duty_q SHALL be 0, and pwm_out SHALL be 0.
REQ-021 ramping SHALL be 1 exactly in RAMP_UP/RAMP_DOWN.
REQ-022 cur_level SHALL saturate at 0 and 31; no wrap-around.

Reset
REQ-023 On reset SHALL set state = IDLE and pwm_out, cur_level, ramping, cnt, divider, duty_q, target_q = 0, effective on the next clock edge.
REQ-024 Reset asserted mid-ramp SHALL abort the ramp; after release, operation restarts from level 0.

Structure
REQ-025 SHALL place the state enum, DUTY_LUT constant and the LUM_LEVELS = 32 constant in shared package lum_pkg.
REQ-026 SHALL instantiate one sub-module pwm_gen (period counter, duty_q register, comparator, boundary strobe); FSM and ramp logic SHALL stay in lum_pwm.

Verification
REQ-027 Reset for 2 cycles with enable = 1, lum_level = 31 -> pwm_out = 0, cur_level = 0, ramping = 0 during reset and on the cycle after.
REQ-028 enable = 1, lum_level = 2 -> ramping = 1; cur_level = 1 after 4 periods, 2 after 8; pwm_out high 132, then 264 cycles per period; ramping = 0 afterwards.
REQ-029 Ramp to 31 -> after 124 periods cur_level = 31 and pwm_out is constantly high over a full period.
REQ-030 While at cur_level = 5 ramping to 10, set lum_level = 3 -> RAMP_DOWN; cur_level steps 4, then 3; then HOLD with duty 396.
REQ-031 Drop enable mid-ramp at level 7 -> next cycle pwm_out = 0, cur_level = 0, ramping = 0; re-enable ramps again from 0.
REQ-032 Run with RAMP_PERIODS = 1 and lum_level toggling between 0 and 31 every 3 periods -> exactly one step per boundary, with no level skips.
